// File: rtl/pipelined_array_mul.sv
// pipelined_array_mul: N x N multiplier with valid/ready on both sides.
// STAGES register stages each fold N/STAGES partial-product rows into a
// running 2N-bit sum. Any stall freezes the whole pipe, so bubbles are not
// removed. The last stage register drives the output directly.
// Optional feature: ARRAY_MUL_ACC_EN adds an acc_clr input and a running
// accumulator that is folded into each result as it enters the last stage.
module pipelined_array_mul #(
  parameter int N      = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_signed,
`ifdef ARRAY_MUL_ACC_EN
  input  logic             acc_clr,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_product,
  output logic             busy
);

  localparam int R = N / STAGES;
  localparam int W = 2 * N;

  // Sum of rows first..first+R-1. In signed mode row N-1 has negative
  // weight, so it is subtracted instead of added.
  function automatic logic [W-1:0] rows_sum(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic         sgn,
                                            input int           first);
    logic [W-1:0] a_ext;
    logic [W-1:0] acc;
    int           row;
    acc   = '0;
    a_ext = sgn ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
    for (int j = 0; j < R; j++) begin
      row = first + j;
      if (b[row]) begin
        if (sgn && (row == N - 1)) acc = acc - (a_ext << row);
        else                       acc = acc + (a_ext << row);
      end
    end
    return acc;
  endfunction

  logic [N-1:0]      a_q     [STAGES];
  logic [N-1:0]      b_q     [STAGES];
  logic [W-1:0]      sum_q   [STAGES];
  logic [STAGES-1:0] s_q;
  logic [STAGES-1:0] v_q;

  logic [N-1:0]      src_a   [STAGES];
  logic [N-1:0]      src_b   [STAGES];
  logic [W-1:0]      src_sum [STAGES];
  logic [STAGES-1:0] src_s;
  logic [STAGES-1:0] src_v;
  logic [W-1:0]      nxt_sum [STAGES];
  logic [W-1:0]      d_sum   [STAGES];

  logic              stall;
  logic [W-1:0]      last_val;

`ifdef ARRAY_MUL_ACC_EN
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] src_c;
  logic [W-1:0]      acc_q;
`endif

  assign stall       = v_q[STAGES-1] & ~out_ready;
  assign in_ready    = ~stall;
  assign out_valid   = v_q[STAGES-1];
  assign out_product = sum_q[STAGES-1];
  assign busy        = |v_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_src
      assign src_a[k]   = in_a;
      assign src_b[k]   = in_b;
      assign src_s[k]   = in_signed;
      assign src_v[k]   = in_valid;
      assign src_sum[k] = '0;
`ifdef ARRAY_MUL_ACC_EN
      assign src_c[k]   = acc_clr;
`endif
    end else begin : g_src
      assign src_a[k]   = a_q[k-1];
      assign src_b[k]   = b_q[k-1];
      assign src_s[k]   = s_q[k-1];
      assign src_v[k]   = v_q[k-1];
      assign src_sum[k] = sum_q[k-1];
`ifdef ARRAY_MUL_ACC_EN
      assign src_c[k]   = c_q[k-1];
`endif
    end

    assign nxt_sum[k] = src_sum[k] + rows_sum(src_a[k], src_b[k], src_s[k], k * R);

    if (k == STAGES - 1) begin : g_last
      assign d_sum[k] = last_val;
    end else begin : g_mid
      assign d_sum[k] = nxt_sum[k];
    end
  end

`ifdef ARRAY_MUL_ACC_EN
  assign last_val = (src_c[STAGES-1] ? '0 : acc_q) + nxt_sum[STAGES-1];

  // Accumulator follows each valid result entering the last stage.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                           acc_q <= '0;
    else if (!stall && src_v[STAGES-1])   acc_q <= last_val;
  end
`else
  assign last_val = nxt_sum[STAGES-1];
`endif

  // Pipeline registers: clear on reset, hold on stall, otherwise shift.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      s_q <= '0;
      v_q <= '0;
`ifdef ARRAY_MUL_ACC_EN
      c_q <= '0;
`endif
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= src_a[k];
        b_q[k]   <= src_b[k];
        sum_q[k] <= d_sum[k];
      end
      s_q <= src_s;
      v_q <= src_v;
`ifdef ARRAY_MUL_ACC_EN
      c_q <= src_c;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_array_mul.sv
// Bench for pipelined_array_mul: a 4-stage DUT for the directed tests plus
// 1-stage and 8-stage DUTs that share the random stream. Scoreboard queues
// hold expected results (and accept cycle) per DUT.
module tb_pipelined_array_mul;
  localparam int S = 4;

  typedef struct {
    logic [15:0] p;
    int          c;
  } ent_t;

  logic        clk = 1'b0;
  logic        clr_n, in_valid, in_signed, out_ready, rnd;
  logic [7:0]  in_a, in_b;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_product;
  logic        r1_ready, r1_valid, r1_busy, r8_ready, r8_valid, r8_busy;
  logic [15:0] r1_p, r8_p;
`ifdef ARRAY_MUL_ACC_EN
  logic        acc_clr;
`endif

  int   n_chk = 0, n_err = 0, cyc = 0, n_pop = 0;
  bit   chk_lat = 1'b1;
  logic [15:0] acc0 = '0, acc1 = '0, acc8 = '0;
  ent_t q0[$], q1[$], q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_array_mul #(.N(8), .STAGES(S)) u_dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
`ifdef ARRAY_MUL_ACC_EN
    .acc_clr(acc_clr),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product), .busy(busy));

  pipelined_array_mul #(.N(8), .STAGES(1)) u_s1 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid & rnd), .in_ready(r1_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
`ifdef ARRAY_MUL_ACC_EN
    .acc_clr(acc_clr),
`endif
    .out_valid(r1_valid), .out_ready(1'b1), .out_product(r1_p), .busy(r1_busy));

  pipelined_array_mul #(.N(8), .STAGES(8)) u_s8 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid & rnd), .in_ready(r8_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
`ifdef ARRAY_MUL_ACC_EN
    .acc_clr(acc_clr),
`endif
    .out_valid(r8_valid), .out_ready(1'b1), .out_product(r8_p), .busy(r8_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] xa, xb;
    xa = s ? {{8{a[7]}}, a} : {8'h00, a};
    xb = s ? {{8{b[7]}}, b} : {8'h00, b};
    return xa * xb;
  endfunction

  // Drive one operand pair and hold it until accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
`ifdef ARRAY_MUL_ACC_EN
    acc_clr = c;
`else
    if (c) in_signed = s;
`endif
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Scoreboard for the 4-stage DUT.
  always @(negedge clk) if (clr_n) begin
    ent_t e;
    if (in_valid && in_ready) begin
`ifdef ARRAY_MUL_ACC_EN
      e.p = (acc_clr ? 16'h0 : acc0) + ref_mul(in_a, in_b, in_signed); acc0 = e.p;
`else
      e.p = ref_mul(in_a, in_b, in_signed);
`endif
      e.c = cyc; q0.push_back(e);
    end
    if (out_valid && out_ready) begin
      n_pop++;
      if (q0.size() == 0) check("s4_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        check("s4_prod", out_product, e.p);
        if (chk_lat) check("s4_latency", cyc - e.c, S);
      end
    end
  end

  // Scoreboards for the 1-stage and 8-stage DUTs.
  always @(negedge clk) if (clr_n) begin
    ent_t e;
    if (in_valid && rnd && r1_ready) begin
`ifdef ARRAY_MUL_ACC_EN
      e.p = (acc_clr ? 16'h0 : acc1) + ref_mul(in_a, in_b, in_signed); acc1 = e.p;
`else
      e.p = ref_mul(in_a, in_b, in_signed);
`endif
      e.c = cyc; q1.push_back(e);
    end
    if (in_valid && rnd && r8_ready) begin
`ifdef ARRAY_MUL_ACC_EN
      e.p = (acc_clr ? 16'h0 : acc8) + ref_mul(in_a, in_b, in_signed); acc8 = e.p;
`else
      e.p = ref_mul(in_a, in_b, in_signed);
`endif
      e.c = cyc; q8.push_back(e);
    end
    if (r1_valid) begin
      if (q1.size() == 0) check("s1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        check("s1_prod", r1_p, e.p);
        check("s1_latency", cyc - e.c, 1);
      end
    end
    if (r8_valid) begin
      if (q8.size() == 0) check("s8_unexpected", 1, 0);
      else begin
        e = q8.pop_front();
        check("s8_prod", r8_p, e.p);
        check("s8_latency", cyc - e.c, 8);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    bit seen;
    clr_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    out_ready = 1'b1; rnd = 1'b0;
`ifdef ARRAY_MUL_ACC_EN
    acc_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", out_product, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); #2 clr_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned corner: 0xFF * 0xFF.
    send(8'hFF, 8'hFF, 1'b0, 1'b1);
    check("u_busy", busy, 1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("u_seen", seen, 1);
`ifndef ARRAY_MUL_ACC_EN
    check("u_ff_ff", out_product, 16'hFE01);
`endif
    repeat (6) @(posedge clk);
    #1;

    // Signed corners back-to-back: results must come in three consecutive cycles.
    send(8'h80, 8'h80, 1'b1, 1'b1);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    send(8'h7F, 8'h80, 1'b1, 1'b0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("sgn_seen", seen, 1);
    repeat (2) begin
      @(negedge clk);
      check("sgn_b2b_valid", out_valid, 1);
    end
    repeat (6) @(posedge clk);
    #1;

    // Back-pressure: six pairs, output held off for five cycles.
    chk_lat = 1'b0;
    pops0 = n_pop;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(8'(i), 8'(i + 1), 1'b0, i == 1);
      end
      begin
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
          @(posedge clk); #1;
          if (out_valid) seen = 1;
        end
        check("bp_seen", seen, 1);
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_busy", busy, 1);
`ifdef ARRAY_MUL_ACC_EN
          check("bp_hold", out_product, (q0.size() > 0) ? q0[0].p : 16'hxxxx);
`else
          check("bp_hold", out_product, 16'h0002);
`endif
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (S + 10) @(posedge clk);
    #1;
    check("bp_drained", q0.size(), 0);
    check("bp_count", n_pop - pops0, 6);
    chk_lat = 1'b1;

`ifdef ARRAY_MUL_ACC_EN
    // Accumulation: 12, then 12 + 30 = 42, then cleared to 4.
    send(8'd3, 8'd4, 1'b0, 1'b1);
    send(8'd5, 8'd6, 1'b0, 1'b0);
    send(8'd2, 8'd2, 1'b0, 1'b1);
    repeat (S + 4) @(posedge clk);
    #1;
    check("acc_drained", q0.size(), 0);
`endif

    // Reset in flight: nothing from before reset may come out afterwards.
    send(8'd9, 8'd9, 1'b0, 1'b1);
    send(8'd7, 8'd3, 1'b1, 1'b0);
    send(8'hF0, 8'h11, 1'b1, 1'b0);
    @(posedge clk); #2;
    check("pre_rst_valid", out_valid, 1);
    clr_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_product", out_product, 0);
    q0.delete();
    acc0 = '0; acc1 = '0; acc8 = '0;
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_valid", out_valid, 0);
    end

    // Random mixed-mode stream to all three pipelines, no back-pressure.
    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      in_signed = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
`ifdef ARRAY_MUL_ACC_EN
      acc_clr = ($urandom_range(0, 3) == 0);
`endif
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rnd_s4_drained", q0.size(), 0);
    check("rnd_s1_drained", q1.size(), 0);
    check("rnd_s8_drained", q8.size(), 0);
    check("rnd_idle", {busy, r1_busy, r8_busy, r1_ready, r8_ready}, 5'b00011);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
